// File: rtl/slave_bus_arbiter.sv
// -----------------------------------------------------------------------------
// slave_bus_arbiter
//   Round-robin arbiter that shares one slave register bus between C_PORTS
//   requesters. One transaction is in flight at a time; the winner gets a
//   one-cycle ACK, and reads also return data on its RDATA lane.
//
// Ports
//   CLK, nRST        clock (rising edge) and synchronous active-low reset
//   REQ/WR           per-port request and direction (1=write, 0=read)
//   ADDR/WDATA       per-port command, port i at [i*C_ADDR_BITS +: C_ADDR_BITS]
//                    and [i*32 +: 32]
//   ACK/RDATA        per-port one-hot completion pulse and held read data
//   S_WE/S_WADDR/S_WDATA, S_RE/S_RADDR/S_RDATA
//                    shared slave bus; S_RDATA is valid C_RD_LATENCY cycles
//                    after S_RE
//   BUSY             FSM not idle, or any request pending
//   DBG_STATE        current FSM state (IDLE=0, ISSUE=1, WAIT=2, DONE=3)
//
// Handshake: a requester raises REQ with WR/ADDR/WDATA and holds all of them
// stable until it sees ACK. REQ high during an IDLE cycle starts a new
// transaction; the cycle after ACK the requester either drops REQ or presents
// its next command, which is then arbitrated like any other request. REQ
// changes while the FSM is busy have no effect, the command is already latched.
// -----------------------------------------------------------------------------
module slave_bus_arbiter #(
  parameter int C_PORTS      = 2,
  parameter int C_ADDR_BITS  = 16,
  parameter int C_RD_LATENCY = 1
) (
  input  logic                           CLK,
  input  logic                           nRST,
  input  logic [C_PORTS-1:0]             REQ,
  input  logic [C_PORTS-1:0]             WR,
  input  logic [C_PORTS*C_ADDR_BITS-1:0] ADDR,
  input  logic [C_PORTS*32-1:0]          WDATA,
  output logic [C_PORTS-1:0]             ACK,
  output logic [C_PORTS*32-1:0]          RDATA,
  output logic                           S_WE,
  output logic [C_ADDR_BITS-1:0]         S_WADDR,
  output logic [31:0]                    S_WDATA,
  output logic                           S_RE,
  output logic [C_ADDR_BITS-1:0]         S_RADDR,
  input  logic [31:0]                    S_RDATA,
  output logic                           BUSY,
  output logic [1:0]                     DBG_STATE
);

  localparam int IDW = (C_PORTS > 1) ? $clog2(C_PORTS) : 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  state_e                 state_q, state_d;
  logic [IDW-1:0]         ptr_q, ptr_d;
  logic [IDW-1:0]         win_q, win_d;
  logic                   wr_q, wr_d;
  logic [C_ADDR_BITS-1:0] addr_q, addr_d;
  logic [31:0]            wdata_q, wdata_d;
  logic [2:0]             cnt_q, cnt_d;
  logic [C_PORTS-1:0]     ack_q, ack_d;
  logic [C_PORTS*32-1:0]  rdata_q, rdata_d;
  logic                   s_we_q, s_we_d;
  logic                   s_re_q, s_re_d;

  // Round-robin pick: scan from the port after the last winner, wrapping, so
  // the last winner itself is considered last.
  logic [IDW-1:0] grant_id;
  always_comb begin
    logic found;
    int   idx;
    found    = 1'b0;
    idx      = 0;
    grant_id = ptr_q;
    for (int k = 1; k <= C_PORTS; k++) begin
      idx = (int'(ptr_q) + k) % C_PORTS;
      if (!found && REQ[idx]) begin
        found    = 1'b1;
        grant_id = IDW'(idx);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    win_d   = win_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    ack_d   = '0;
    s_we_d  = 1'b0;
    s_re_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (|REQ) begin
          win_d   = grant_id;
          ptr_d   = grant_id;
          wr_d    = WR[grant_id];
          addr_d  = ADDR[int'(grant_id)*C_ADDR_BITS +: C_ADDR_BITS];
          wdata_d = WDATA[int'(grant_id)*32 +: 32];
          // Strobes are registered, so they are raised on entry to ISSUE.
          s_we_d  = WR[grant_id];
          s_re_d  = !WR[grant_id];
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (wr_q) begin
          ack_d[win_q] = 1'b1;
          state_d      = ST_DONE;
        end else begin
          cnt_d   = 3'(C_RD_LATENCY);
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q - 3'd1;
        // Counter reaches 1 in the cycle the slave data is valid.
        if (cnt_q == 3'd1) begin
          rdata_d[int'(win_q)*32 +: 32] = S_RDATA;
          ack_d[win_q]                  = 1'b1;
          state_d                       = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_q <= ST_IDLE;
      ptr_q   <= IDW'(C_PORTS - 1);
      win_q   <= '0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      cnt_q   <= '0;
      ack_q   <= '0;
      rdata_q <= '0;
      s_we_q  <= 1'b0;
      s_re_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      win_q   <= win_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
      ack_q   <= ack_d;
      rdata_q <= rdata_d;
      s_we_q  <= s_we_d;
      s_re_q  <= s_re_d;
    end
  end

  assign ACK       = ack_q;
  assign RDATA     = rdata_q;
  assign S_WE      = s_we_q;
  assign S_WADDR   = addr_q;
  assign S_WDATA   = wdata_q;
  assign S_RE      = s_re_q;
  assign S_RADDR   = addr_q;
  assign BUSY      = (state_q != ST_IDLE) || (|REQ);
  assign DBG_STATE = state_q;

endmodule

// File: tb/tb_slave_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_slave_bus_arbiter
//   Two arbiter instances: A (2 ports, read latency 1) and B (4 ports, read
//   latency 3). They share the requester/slave stimulus; `sel` picks which one
//   the slave model and the reference model observe. Each switch is done
//   under reset so the observed instance always starts clean.
// -----------------------------------------------------------------------------
module tb_slave_bus_arbiter;

  localparam int AW   = 16;
  localparam int MAXP = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic nrst;
  int   rst_cycles;
  logic rst_at_edge;

  // ---------------- stimulus signals ----------------
  logic [MAXP-1:0]      req_v;
  logic [MAXP-1:0]      wr_v;
  logic [MAXP*AW-1:0]   addr_bus;
  logic [MAXP*32-1:0]   wdata_bus;
  logic [31:0]          s_rdata;

  // ---------------- DUT A: 2 ports, latency 1 ----------------
  logic [1:0]  ack_a;
  logic [63:0] rdata_a;
  logic        s_we_a, s_re_a, busy_a;
  logic [15:0] s_waddr_a, s_raddr_a;
  logic [31:0] s_wdata_a;
  logic [1:0]  dbg_a;

  slave_bus_arbiter #(.C_PORTS(2), .C_ADDR_BITS(AW), .C_RD_LATENCY(1)) u_dut_a (
    .CLK(clk), .nRST(nrst), .REQ(req_v[1:0]), .WR(wr_v[1:0]),
    .ADDR(addr_bus[2*AW-1:0]), .WDATA(wdata_bus[63:0]),
    .ACK(ack_a), .RDATA(rdata_a),
    .S_WE(s_we_a), .S_WADDR(s_waddr_a), .S_WDATA(s_wdata_a),
    .S_RE(s_re_a), .S_RADDR(s_raddr_a), .S_RDATA(s_rdata),
    .BUSY(busy_a), .DBG_STATE(dbg_a)
  );

  // ---------------- DUT B: 4 ports, latency 3 ----------------
  logic [3:0]   ack_b;
  logic [127:0] rdata_b;
  logic         s_we_b, s_re_b, busy_b;
  logic [15:0]  s_waddr_b, s_raddr_b;
  logic [31:0]  s_wdata_b;
  logic [1:0]   dbg_b;

  slave_bus_arbiter #(.C_PORTS(4), .C_ADDR_BITS(AW), .C_RD_LATENCY(3)) u_dut_b (
    .CLK(clk), .nRST(nrst), .REQ(req_v), .WR(wr_v),
    .ADDR(addr_bus), .WDATA(wdata_bus),
    .ACK(ack_b), .RDATA(rdata_b),
    .S_WE(s_we_b), .S_WADDR(s_waddr_b), .S_WDATA(s_wdata_b),
    .S_RE(s_re_b), .S_RADDR(s_raddr_b), .S_RDATA(s_rdata),
    .BUSY(busy_b), .DBG_STATE(dbg_b)
  );

  // ---------------- observed-instance mux ----------------
  logic               sel;
  int                 n_ports;
  int                 rd_lat;
  logic [MAXP-1:0]    m_ack;
  logic [MAXP*32-1:0] m_rdata;
  logic               m_we, m_re, m_busy;
  logic [15:0]        m_waddr, m_raddr;
  logic [31:0]        m_wdata;

  always_comb begin
    if (sel) begin
      m_ack = ack_b;  m_rdata = rdata_b;
      m_we = s_we_b;  m_re = s_re_b;  m_busy = busy_b;
      m_waddr = s_waddr_b; m_raddr = s_raddr_b; m_wdata = s_wdata_b;
    end else begin
      m_ack = {2'b00, ack_a};  m_rdata = {64'd0, rdata_a};
      m_we = s_we_a;  m_re = s_re_a;  m_busy = busy_a;
      m_waddr = s_waddr_a; m_raddr = s_raddr_a; m_wdata = s_wdata_a;
    end
  end

  // ---------------- checking ----------------
  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- requesters and slave model ----------------
  typedef struct packed {
    logic        wr;
    logic [15:0] addr;
    logic [31:0] wdata;
  } cmd_t;

  cmd_t        cmd_q [MAXP][$];
  logic        gap_en;
  logic [MAXP-1:0] ack_obs;
  logic [16:0] re_obs;
  logic [16:0] re_pipe [8];
  logic [31:0] mem [int unsigned];

  function automatic logic [31:0] slave_rd(input logic [15:0] a);
    if (mem.exists(32'(a))) return mem[32'(a)];
    return {~a, a} ^ 32'h5A5A_0F0F;
  endfunction

  function automatic cmd_t rand_cmd();
    cmd_t c;
    c.wr    = 1'($urandom_range(0, 1));
    c.addr  = 16'($urandom_range(0, 15) * 4);
    c.wdata = $urandom;
    return c;
  endfunction

  initial begin : drive
    cmd_t c;
    forever begin
      @(posedge clk);
      rst_at_edge = !nrst;
      #1;
      if (rst_cycles > 0) begin
        nrst = 1'b0;
        rst_cycles--;
      end else begin
        nrst = 1'b1;
      end
      // slave: data valid rd_lat cycles after the cycle S_RE was seen, noise otherwise
      for (int i = 7; i > 0; i--) re_pipe[i] = re_pipe[i-1];
      re_pipe[0] = re_obs;
      if (re_pipe[rd_lat-1][16]) s_rdata = slave_rd(re_pipe[rd_lat-1][15:0]);
      else                       s_rdata = $urandom;
      // requesters: hold until ACK, then drop or present the next command
      for (int p = 0; p < MAXP; p++) begin
        if (p >= n_ports) begin
          req_v[p] = 1'b0;
          continue;
        end
        if (req_v[p] && ack_obs[p]) req_v[p] = 1'b0;
        if (!req_v[p]) begin
          if (cmd_q[p].size() > 0 && (!gap_en || $urandom_range(0, 1) == 1)) begin
            c = cmd_q[p].pop_front();
            req_v[p] = 1'b1;
            wr_v[p]  = c.wr;
            addr_bus[p*AW +: AW]   = c.addr;
            wdata_bus[p*32 +: 32]  = c.wdata;
          end else begin
            wr_v[p] = 1'($urandom_range(0, 1));
            addr_bus[p*AW +: AW]  = 16'($urandom);
            wdata_bus[p*32 +: 32] = $urandom;
          end
        end
      end
    end
  end

  // ---------------- reference model / monitor ----------------
  // Transaction-level view: an IDLE cycle with requests produces a strobe the
  // next cycle for the round-robin winner, and the ACK arrives a fixed number
  // of cycles after the strobe (1 for writes, latency+1 for reads).
  int          cyc = 0;
  int          model_ptr;
  logic        model_active;
  logic        active_now;
  int          due;
  int          win;
  logic        win_wr;
  logic [31:0] win_rd;
  logic        exp_strobe_next;
  logic [MAXP-1:0] req_prev;
  logic [MAXP-1:0] exp_ack;
  logic [31:0] rdata_exp [MAXP];
  int          ack_log [$];
  int          strobe_cnt = 0;
  int          last_strobe_cyc, last_ack_cyc;
  logic [15:0] last_waddr;
  logic [31:0] last_wdata;

  function automatic int rr_pick(input int ptr, input logic [MAXP-1:0] req, input int n);
    for (int k = 1; k <= n; k++) begin
      if (req[(ptr + k) % n]) return (ptr + k) % n;
    end
    return ptr;
  endfunction

  initial begin : monitor
    forever begin
      @(negedge clk);
      cyc++;
      ack_obs = m_ack;
      re_obs  = {m_re, m_raddr};
      if (m_we) begin
        mem[32'(m_waddr)] = m_wdata;
        last_waddr = m_waddr;
        last_wdata = m_wdata;
      end
      if (m_we || m_re) begin
        strobe_cnt++;
        last_strobe_cyc = cyc;
      end
      if (rst_at_edge) begin
        check_eq("rst_ack", 64'(m_ack), 64'd0);
        check_eq("rst_strobes", {62'd0, m_we, m_re}, 64'd0);
        check_eq("rst_addr_data", {m_waddr, m_raddr, m_wdata}, 64'd0);
        for (int p = 0; p < n_ports; p++) begin
          check_eq("rst_rdata", 64'(m_rdata[p*32 +: 32]), 64'd0);
          rdata_exp[p] = '0;
        end
        model_ptr    = n_ports - 1;
        model_active = 1'b0;
        active_now   = 1'b0;
      end else begin
        exp_ack = '0;
        check_eq("strobe", 64'(m_we | m_re), 64'(exp_strobe_next));
        if (exp_strobe_next) begin
          win       = rr_pick(model_ptr, req_prev, n_ports);
          model_ptr = win;
          win_wr    = wr_v[win];
          check_eq("strobe_kind", {62'd0, m_we, m_re}, {62'd0, win_wr, !win_wr});
          if (win_wr) begin
            check_eq("s_waddr", 64'(m_waddr), 64'(addr_bus[win*AW +: AW]));
            check_eq("s_wdata", 64'(m_wdata), 64'(wdata_bus[win*32 +: 32]));
          end else begin
            check_eq("s_raddr", 64'(m_raddr), 64'(addr_bus[win*AW +: AW]));
            win_rd = slave_rd(addr_bus[win*AW +: AW]);
          end
          due          = cyc + (win_wr ? 1 : rd_lat + 1);
          model_active = 1'b1;
        end
        active_now = model_active;
        if (model_active && cyc == due) begin
          exp_ack[win] = 1'b1;
          if (!win_wr) rdata_exp[win] = win_rd;
          model_active = 1'b0;
          ack_log.push_back(win);
          last_ack_cyc = cyc;
        end
        check_eq("ack", 64'(m_ack), 64'(exp_ack));
        for (int p = 0; p < n_ports; p++)
          check_eq("rdata", 64'(m_rdata[p*32 +: 32]), 64'(rdata_exp[p]));
      end
      check_eq("we_re_exclusive", 64'(m_we & m_re), 64'd0);
      check_eq("busy", 64'(m_busy), 64'(active_now | (|req_v)));
      exp_strobe_next = !active_now && (|req_v) && nrst;
      req_prev        = req_v;
    end
  end

  // ---------------- sequencing helpers ----------------
  task automatic drain(input string tag);
    logic done;
    done = 1'b0;
    for (int i = 0; i < 600 && !done; i++) begin
      @(posedge clk);
      done = (req_v == '0) && !model_active;
      for (int p = 0; p < MAXP; p++) if (cmd_q[p].size() != 0) done = 1'b0;
    end
    check_eq(tag, 64'(done), 64'd1);
  endtask

  task automatic reset_to(input logic s);
    rst_cycles = 3;
    @(posedge clk);
    @(posedge clk);
    sel     = s;
    n_ports = s ? 4 : 2;
    rd_lat  = s ? 3 : 1;
    repeat (4) @(posedge clk);
  endtask

  task automatic check_order(input string tag, input int exp_seq [$]);
    check_eq({tag, "_count"}, 64'(ack_log.size()), 64'(exp_seq.size()));
    for (int i = 0; i < exp_seq.size() && i < ack_log.size(); i++)
      check_eq(tag, 64'(ack_log[i]), 64'(exp_seq[i]));
  endtask

  initial begin : watchdog
    #600000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  // ---------------- test sequence ----------------
  initial begin : main
    cmd_t c;
    int   s0;
    nrst = 1'b0; rst_cycles = 3; rst_at_edge = 1'b1;
    sel = 1'b0; n_ports = 2; rd_lat = 1; gap_en = 1'b0;
    req_v = '0; wr_v = '0; addr_bus = '0; wdata_bus = '0; s_rdata = '0;
    ack_obs = '0; re_obs = '0; exp_strobe_next = 1'b0; model_active = 1'b0;
    active_now = 1'b0; model_ptr = 1; req_prev = '0;
    for (int i = 0; i < 8; i++) re_pipe[i] = '0;
    for (int p = 0; p < MAXP; p++) rdata_exp[p] = '0;
    repeat (6) @(posedge clk);

    // 1: single write on port 0
    ack_log.delete();
    c = '{wr: 1'b1, addr: 16'h0010, wdata: 32'hDEADBEEF};
    cmd_q[0].push_back(c);
    drain("t1_drain");
    check_eq("t1_waddr", 64'(last_waddr), 64'h0010);
    check_eq("t1_wdata", 64'(last_wdata), 64'hDEADBEEF);
    check_order("t1_order", '{0});

    // 2: read on port 1, port 0 read data untouched
    ack_log.delete();
    mem[32'h24] = 32'h12345678;
    c = '{wr: 1'b0, addr: 16'h0024, wdata: 32'h0};
    cmd_q[1].push_back(c);
    drain("t2_drain");
    check_eq("t2_rdata_p1", 64'(m_rdata[63:32]), 64'h12345678);
    check_eq("t2_rdata_p0", 64'(m_rdata[31:0]), 64'd0);
    check_order("t2_order", '{1});

    // 3: simultaneous held requests after reset alternate starting at port 0
    reset_to(1'b0);
    ack_log.delete();
    for (int k = 0; k < 2; k++) begin
      cmd_q[0].push_back(rand_cmd());
      cmd_q[1].push_back(rand_cmd());
    end
    drain("t3_drain");
    check_order("t3_order", '{0, 1, 0, 1});

    // 4: reset while waiting for read data, request retried afterwards
    ack_log.delete();
    mem[32'h30] = 32'hCAFE_0030;
    c = '{wr: 1'b0, addr: 16'h0030, wdata: 32'h0};
    cmd_q[0].push_back(c);
    s0 = strobe_cnt;
    for (int i = 0; i < 20 && strobe_cnt == s0; i++) @(posedge clk);
    check_eq("t4_strobe_seen", 64'(strobe_cnt != s0), 64'd1);
    rst_cycles = 1;
    drain("t4_drain");
    check_order("t4_order", '{0});
    check_eq("t4_rdata_p0", 64'(m_rdata[31:0]), 64'hCAFE_0030);

    // random traffic on instance A
    gap_en = 1'b1;
    for (int i = 0; i < 60; i++) cmd_q[$urandom_range(0, 1)].push_back(rand_cmd());
    drain("rand_a_drain");
    gap_en = 1'b0;

    // 5: latency-3 read on instance B
    reset_to(1'b1);
    ack_log.delete();
    c = '{wr: 1'b0, addr: 16'h0008, wdata: 32'h0};
    cmd_q[0].push_back(c);
    drain("t5_drain");
    check_eq("t5_strobe_to_ack", 64'(last_ack_cyc - last_strobe_cyc), 64'd4);
    check_eq("t5_rdata_p0", 64'(m_rdata[31:0]), 64'(slave_rd(16'h0008)));
    check_order("t5_order", '{0});

    // 6: four ports all requesting, strict rotation
    reset_to(1'b1);
    ack_log.delete();
    for (int k = 0; k < 2; k++)
      for (int p = 0; p < 4; p++) cmd_q[p].push_back(rand_cmd());
    drain("t6_drain");
    check_order("t6_order", '{0, 1, 2, 3, 0, 1, 2, 3});

    // random traffic on instance B
    gap_en = 1'b1;
    for (int i = 0; i < 80; i++) cmd_q[$urandom_range(0, 3)].push_back(rand_cmd());
    drain("rand_b_drain");

    repeat (4) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
